// File: rtl/regfile_pkg.sv
// Constants and state type shared by the 32x32 register file and its debug read-out engine.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register range through the register file's combinational read port
// and streams each captured value out as (index, data) beats over valid/ready.
module regfile_dump_reader
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W-1:0] m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_last_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_reg <= '0;
      rf_addr    <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_index    <= '0;
      m_last     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            if (first_reg <= last_reg) begin
              r_last_reg <= last_reg;
              rf_addr    <= first_reg;
              busy       <= 1'b1;
              r_state    <= READ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        READ: begin
          // rf_addr has been stable for the whole cycle, so rf_data is the settled value.
          m_data  <= rf_data;
          m_index <= rf_addr;
          m_last  <= (rf_addr == r_last_reg);
          m_valid <= 1'b1;
          r_state <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            if (m_last) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= IDLE;
            end else begin
              rf_addr <= rf_addr + 1'b1;
              r_state <= READ;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised and directed bench for regfile_dump_reader against a schedule-based dump model.
module tb_regfile_dump_reader;
  import regfile_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] first_reg;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_index;
  logic              m_last;
  logic              busy;
  logic              done;
  logic              err;

  logic [DATA_W-1:0] rf [NUM_REGS];
  assign rf_data = rf[rf_addr];

  int checks = 0;
  int errors = 0;
  int tc = 0;

  regfile_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .first_reg(first_reg),
    .last_reg (last_reg),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a dump is a list of registers; each is read in the cycle after the
  // start (or after the previous beat's acceptance) and offered the cycle after.
  logic              e_active = 1'b0;
  logic              e_read_now = 1'b0;
  int                e_cur = 0;
  int                e_lastidx = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic              e_valid = 1'b0;
  logic [DATA_W-1:0] e_data = '0;
  logic [ADDR_W-1:0] e_index = '0;
  logic              e_last = 1'b0;
  logic              e_done = 1'b0;
  logic              e_err = 1'b0;

  always @(posedge clk) begin
    e_done = 1'b0;
    e_err  = 1'b0;
    if (reset) begin
      e_active = 1'b0; e_read_now = 1'b0; e_addr = '0;
      e_valid = 1'b0; e_data = '0; e_index = '0; e_last = 1'b0;
    end else if (!e_active) begin
      if (start) begin
        if (int'(first_reg) <= int'(last_reg)) begin
          e_active = 1'b1; e_read_now = 1'b1;
          e_cur = int'(first_reg); e_lastidx = int'(last_reg);
          e_addr = first_reg;
        end else begin
          e_err = 1'b1;
        end
      end
    end else if (e_read_now) begin
      e_read_now = 1'b0;
      e_valid = 1'b1;
      e_data  = rf[e_cur];
      e_index = ADDR_W'(e_cur);
      e_last  = (e_cur == e_lastidx);
    end else if (e_valid && m_ready) begin
      e_valid = 1'b0;
      if (e_cur == e_lastidx) begin
        e_active = 1'b0; e_done = 1'b1;
      end else begin
        e_cur = e_cur + 1; e_read_now = 1'b1; e_addr = ADDR_W'(e_cur);
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (busy !== e_active || m_valid !== e_valid || done !== e_done ||
        err !== e_err || rf_addr !== e_addr) begin
      errors++;
      $display("FAIL ctrl t=%0t got busy=%b valid=%b done=%b err=%b addr=%0d exp busy=%b valid=%b done=%b err=%b addr=%0d",
               $time, busy, m_valid, done, err, rf_addr, e_active, e_valid, e_done, e_err, e_addr);
    end
    if (e_valid || reset) begin
      checks++;
      if (m_data !== e_data || m_index !== e_index || m_last !== e_last) begin
        errors++;
        $display("FAIL beat t=%0t got (%0d,%h,%b) exp (%0d,%h,%b)",
                 $time, m_index, m_data, m_last, e_index, e_data, e_last);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    tc++;
  endtask

  task automatic begin_dump(input int f, input int l, input logic rdy);
    @(negedge clk);
    tc = 0;
    first_reg = ADDR_W'(f);
    last_reg  = ADDR_W'(l);
    m_ready   = rdy;
    start     = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    start = 1'b0;
    m_ready = 1'b1;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk(nm, {31'd0, busy}, 32'd0);
  endtask

  task automatic init_rf();
    for (int i = 0; i < int'(NUM_REGS); i++) rf[i] = 32'(i * 7 + 100);
    rf[2] = 32'd6; rf[3] = 32'd34; rf[4] = 32'd5;
    rf[9] = 32'd45; rf[10] = 32'd70; rf[11] = 32'd41;
  endtask

  initial begin
    int beats;
    int done_cyc;
    int f;
    int l;
    init_rf();
    reset = 1'b1; start = 1'b0; first_reg = '0; last_reg = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(rf_addr), 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    // Basic 2..4 dump with ready held high.
    begin_dump(2, 4, 1'b1);
    step(); start = 1'b0;
    chk("t1_busy_c1", {31'd0, busy}, 32'd1);
    chk("t1_valid_c1", {31'd0, m_valid}, 32'd0);
    step();
    chk("t1_valid_c2", {31'd0, m_valid}, 32'd1);
    chk("t1_idx_c2", 32'(m_index), 32'd2);
    chk("t1_data_c2", m_data, 32'd6);
    step();
    chk("t1_gap_c3", {31'd0, m_valid}, 32'd0);
    step();
    chk("t1_data_c4", m_data, 32'd34);
    chk("t1_idx_c4", 32'(m_index), 32'd3);
    step(); step();
    chk("t1_data_c6", m_data, 32'd5);
    chk("t1_last_c6", {31'd0, m_last}, 32'd1);
    step();
    chk("t1_done_c7", {31'd0, done}, 32'd1);
    chk("t1_busy_c7", {31'd0, busy}, 32'd0);
    step();
    chk("t1_done_c8", {31'd0, done}, 32'd0);

    // Backpressure on the first beat.
    begin_dump(2, 4, 1'b1);
    step(); start = 1'b0;
    step(); m_ready = 1'b0;
    chk("t2_valid_c2", {31'd0, m_valid}, 32'd1);
    step();
    chk("t2_data_c3", m_data, 32'd6);
    step();
    chk("t2_idx_c4", 32'(m_index), 32'd2);
    chk("t2_valid_c4", {31'd0, m_valid}, 32'd1);
    step(); m_ready = 1'b1;
    chk("t2_valid_c5", {31'd0, m_valid}, 32'd1);
    step();
    chk("t2_valid_c6", {31'd0, m_valid}, 32'd0);
    step();
    chk("t2_idx_c7", 32'(m_index), 32'd3);
    wait_idle("t2_idle");

    // Reversed range is rejected.
    begin_dump(5, 3, 1'b1);
    step(); start = 1'b0;
    chk("t3_err_c1", {31'd0, err}, 32'd1);
    chk("t3_busy_c1", {31'd0, busy}, 32'd0);
    step();
    chk("t3_err_c2", {31'd0, err}, 32'd0);
    chk("t3_valid_c2", {31'd0, m_valid}, 32'd0);

    // Write to x10 lands after x9 is sent but before x10 is read.
    begin_dump(9, 11, 1'b1);
    step(); start = 1'b0;
    step(); rf[10] = 32'hDEADBEEF;
    chk("t5_data9", m_data, 32'd45);
    step(); step();
    chk("t5_idx10", 32'(m_index), 32'd10);
    chk("t5_data10", m_data, 32'hDEADBEEF);
    step(); step();
    chk("t5_data11", m_data, 32'd41);
    wait_idle("t5_idle");

    // Reset while a beat is pending.
    begin_dump(2, 4, 1'b0);
    step(); start = 1'b0;
    step(); reset = 1'b1;
    chk("t6_valid_pre", {31'd0, m_valid}, 32'd1);
    step(); reset = 1'b0;
    chk("t6_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_addr", 32'(rf_addr), 32'd0);
    repeat (4) begin
      step();
      chk("t6_nodone", {31'd0, done}, 32'd0);
    end
    begin_dump(3, 3, 1'b1);
    step(); start = 1'b0;
    step();
    chk("t6_data", m_data, 32'd34);
    chk("t6_last", {31'd0, m_last}, 32'd1);
    step();
    chk("t6_done", {31'd0, done}, 32'd1);

    // Full-file dump of a cleared register file.
    for (int i = 0; i < int'(NUM_REGS); i++) rf[i] = '0;
    begin_dump(0, 31, 1'b1);
    beats = 0;
    done_cyc = -1;
    while (done_cyc < 0 && tc < 100) begin
      step(); start = 1'b0;
      if (m_valid) begin
        chk("t4_idx", 32'(m_index), 32'(beats));
        chk("t4_last", {31'd0, m_last}, {31'd0, beats == 31});
        beats++;
      end
      if (done) done_cyc = tc;
    end
    chk("t4_beats", 32'(beats), 32'd32);
    chk("t4_done_cyc", 32'(done_cyc), 32'd65);

    // Randomised traffic against the model.
    init_rf();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      m_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 3) == 0);
      f = $urandom_range(0, 31);
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 31) : $urandom_range(f, (f + 6 > 31) ? 31 : f + 6);
      first_reg = ADDR_W'(f);
      last_reg  = ADDR_W'(l);
      if ($urandom_range(0, 1) == 1) rf[$urandom_range(0, 31)] = $urandom;
    end
    reset = 1'b0;
    wait_idle("rand_idle");
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
